irq_sched: RTL and testbench
============================

# irq_sched

Memory-mapped interrupt scheduler between the timer/peripheral IRQ lines and the CPU's CP0 interrupt input. Latches up to six sources, applies per-source mask and edge/level mode, and picks the highest-priority pending source. Raises a single request to the CPU and tracks one in-service interrupt until software writes end-of-interrupt (EOI). Lives on the same peripheral bus as the timers at 0x0000_7f20–0x0000_7f2f.

## Interface
- N_SRC, 6, number of interrupt sources (1..8); source 0 has the highest priority.
- BASE, 32'h0000_7f20, byte base address of the 16-byte register window.
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- Addr  input  32  byte address from the bus.
- WE  input  1  bus write enable.
- Din  input  32  bus write data.
- Dout  output  32  read data, combinational from Addr[3:2].
- irq_src  input  N_SRC  raw interrupt lines from timers/peripherals, synchronous to clk.
- irq_ack  input  1  one-cycle pulse from CP0 when it takes the interrupt exception.
- cpu_irq  output  1  interrupt request to CP0.
- irq_id  output  3  id of the in-service source, valid while irq_active.
- irq_active  output  1  high while an interrupt is in service.

## Operation
- Chip select: CS = (Addr >= BASE) && (Addr <= BASE+15). Writes only take effect when WE & CS. Word select is Addr[3:2].
- Reg 0 CTRL: [N_SRC-1:0] mask (1 = enabled), [8] GE global enable. Other bits read 0, writes to them ignored.
- Reg 1 MODE: [N_SRC-1:0] 1 = rising-edge triggered, 0 = level (active high).
- Reg 2 PEND:
  - Read gives the effective pending vector.
  - Write-1-to-clear on edge-mode bits. Level bits ignore writes.
- Reg 3 ISR:
  - Read gives {irq_active, 28'b0, irq_id}.
  - Any write is EOI.
- Edge detection:
  - prev register holds irq_src from the previous cycle.
  - An edge-mode source with irq_src & ~prev sets its pend bit.
  - A set in the same cycle as a W1C write wins.
- Effective pending vector = (MODE & pend) | (~MODE & irq_src).
- Eligible vector = pending & mask, gated by GE. The winner is its lowest-index set bit.
- FSM states and transitions:
  - IDLE → REQ when eligible != 0.
  - REQ:
    - cpu_irq = 1.
    - On irq_ack: latch the winner evaluated in that cycle into irq_id, clear its edge pend bit, go to SERVICE.
    - Without ack, if eligible becomes 0 (masked, GE cleared, level dropped, W1C), return to IDLE and drop cpu_irq.
  - SERVICE:
    - irq_active = 1, cpu_irq = 0.
    - No nesting: new sources only accumulate as pending.
    - An EOI write goes to IDLE.
  - irq_ack outside REQ is ignored. EOI outside SERVICE is ignored.
- Changing MODE on a bit clears that bit's edge pend.

## Timing
- Reset values: state IDLE; CTRL, MODE, pend, prev all 0; cpu_irq 0; irq_active 0; irq_id 0; Dout 0 for every register.
- Latency:
  - Edge source rising at edge n: pend set at n+1, cpu_irq high after n+1 (REQ entered at n+2 edge; cpu_irq is a state decode).
  - Level source: cpu_irq high one cycle after the level is seen.
- cpu_irq falls on the edge that samples irq_ack.
- After EOI at edge m, IDLE at m. If eligible != 0, REQ at m+1.
- A bus write to any register in the same cycle as irq_ack: both are applied. The ack uses pre-write register values.
- Reset asserted mid-REQ or mid-SERVICE: outputs go to reset values immediately (asynchronous). All pend bits are lost.

## Test plan
- Reset then reads: drive reset low mid-REQ → cpu_irq = 0 immediately; reads of 0x7f20/24/28/2c all return 0.
- Single edge source: CTRL = 0x101, MODE = 0x01, pulse irq_src[0] one cycle → cpu_irq high 2 edges later; ack → irq_id = 0, irq_active = 1, PEND = 0; write 0x7f2c → back to IDLE, cpu_irq stays 0.
- Priority: CTRL = 0x13F, MODE = 0x3F, edges on sources 4 and 1 in the same cycle → ack gives irq_id = 1; after EOI, cpu_irq reasserts, second ack gives irq_id = 4.
- Level withdraw: MODE = 0, CTRL = 0x104, hold irq_src[2] then drop it before ack → cpu_irq falls, state IDLE, a late irq_ack is ignored (irq_active stays 0).
- Masking/GE: pending edge on source 3 with mask bit 0 → no cpu_irq; set the mask bit → request. Clear GE in REQ → cpu_irq drops; PEND still reads 0x08.
- W1C race: an edge on source 5 in the same cycle as a write of 0x20 to 0x7f28 → PEND bit 5 remains set.

Source files
------------

// File: rtl/irq_sched.sv
// irq_sched: memory-mapped six-source interrupt scheduler with mask, edge/level mode and one in-service slot
module irq_sched #(
  parameter int          N_SRC = 6,
  parameter logic [31:0] BASE  = 32'h0000_7f20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      Addr,
  input  logic             WE,
  input  logic [31:0]      Din,
  output logic [31:0]      Dout,
  input  logic [N_SRC-1:0] irq_src,
  input  logic             irq_ack,
  output logic             cpu_irq,
  output logic [2:0]       irq_id,
  output logic             irq_active
);
  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
  state_t state, state_n;
  logic [N_SRC-1:0] mask, mode, pend, prev, eff, elig, lsb, rise, clr, mode_chg, pend_n;
  logic ge, cs, wr_ctrl, wr_mode, wr_pend, eoi, take, unused_din;
  logic [2:0] win;
  assign unused_din = ^Din;
  assign cs       = (Addr >= BASE) && (Addr <= BASE + 32'd15);
  assign wr_ctrl  = WE && cs && Addr[3:2] == 2'd0;
  assign wr_mode  = WE && cs && Addr[3:2] == 2'd1;
  assign wr_pend  = WE && cs && Addr[3:2] == 2'd2;
  assign eoi      = WE && cs && Addr[3:2] == 2'd3;
  assign eff      = (mode & pend) | (~mode & irq_src);
  assign elig     = ge ? eff & mask : '0;
  assign lsb      = elig & (~elig + 1'b1);
  assign rise     = mode & irq_src & ~prev;
  assign take     = state == REQ && irq_ack && |elig;
  assign clr      = (wr_pend ? Din[N_SRC-1:0] & mode : '0) | (take ? lsb : '0);
  assign mode_chg = wr_mode ? Din[N_SRC-1:0] ^ mode : '0;
  // a new edge beats any clear in the same cycle; a mode flip always discards the latched edge
  assign pend_n   = ((pend & ~clr) | rise) & ~mode_chg;
  assign cpu_irq    = state == REQ;
  assign irq_active = state == SERVICE;
  always_comb begin
    win = '0;
    for (int i = N_SRC - 1; i >= 0; i--)
      if (elig[i]) win = 3'(i);
  end
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (|elig ? REQ : IDLE)
            : state == REQ  ? (take ? SERVICE : |elig ? REQ : IDLE)
            : (eoi ? IDLE : SERVICE);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      mask   <= '0;
      ge     <= 1'b0;
      mode   <= '0;
      pend   <= '0;
      prev   <= '0;
      irq_id <= '0;
    end else begin
      state <= state_n;
      prev  <= irq_src;
      pend  <= pend_n;
      if (wr_ctrl) begin
        mask <= Din[N_SRC-1:0];
        ge   <= Din[8];
      end
      if (wr_mode) mode <= Din[N_SRC-1:0];
      if (take) irq_id <= win;
    end
  end
  assign Dout = Addr[3:2] == 2'd0 ? (32'(mask) | {23'b0, ge, 8'b0})
              : Addr[3:2] == 2'd1 ? 32'(mode)
              : Addr[3:2] == 2'd2 ? 32'(eff)
              : {irq_active, 28'b0, irq_id};
endmodule

// File: tb/tb_irq_sched.sv
// tb_irq_sched: scoreboard bench for irq_sched covering edge/level requests, priority, masking, W1C race and async reset
module tb_irq_sched;
  localparam logic [31:0] BASE = 32'h0000_7f20;
  logic        clk = 0, reset = 0, WE = 0, irq_ack = 0;
  logic [31:0] Addr = 0, Din = 0, Dout, rdata;
  logic [5:0]  irq_src = 0;
  logic        cpu_irq, irq_active;
  logic [2:0]  irq_id;
  int          checks = 0, failures = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];
  always #5 clk = ~clk;
  irq_sched #(.N_SRC(6), .BASE(BASE)) dut (
    .clk(clk), .reset(reset), .Addr(Addr), .WE(WE), .Din(Din), .Dout(Dout),
    .irq_src(irq_src), .irq_ack(irq_ack), .cpu_irq(cpu_irq), .irq_id(irq_id), .irq_active(irq_active)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask
  task automatic expect_val(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask
  task automatic observe(input logic [31:0] obs);
    if (exp_q.size() == 0) chk("sb_underflow", 32'(exp_q.size()), 32'd1);
    else chk(tag_q.pop_front(), obs, exp_q.pop_front());
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    Addr = a; Din = d; WE = 1;
    tick();
    WE = 0;
  endtask
  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    Addr = a;
    #1;
    d = Dout;
  endtask
  task automatic pulse_ack;
    irq_ack = 1;
    tick();
    irq_ack = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    repeat (2) tick();
    reset = 1;
    tick();
    expect_val("rst_cpu_irq", 0); observe(32'(cpu_irq));
    expect_val("rst_active", 0);  observe(32'(irq_active));
    for (int i = 0; i < 4; i++) begin
      expect_val($sformatf("rst_reg%0d", i), 0);
      rd(BASE + 32'(4 * i), rdata); observe(rdata);
    end
    // single edge source
    wr(BASE, 32'h101);
    wr(BASE + 4, 32'h01);
    irq_src = 6'h01;
    expect_val("e1_cpu_lo", 0);
    tick();
    observe(32'(cpu_irq));
    expect_val("e1_pend", 32'h1); rd(BASE + 8, rdata); observe(rdata);
    irq_src = 0;
    expect_val("e1_cpu_hi", 1);
    tick();
    observe(32'(cpu_irq));
    expect_val("e1_id", 0); expect_val("e1_active", 1); expect_val("e1_cpu_ack", 0); expect_val("e1_pend_clr", 0);
    pulse_ack();
    observe(32'(irq_id)); observe(32'(irq_active)); observe(32'(cpu_irq));
    rd(BASE + 8, rdata); observe(rdata);
    expect_val("e1_isr", 32'h8000_0000); rd(BASE + 12, rdata); observe(rdata);
    expect_val("e1_eoi_idle", 0);
    wr(BASE + 12, 0);
    observe(32'(irq_active));
    expect_val("e1_cpu_stays_lo", 0);
    tick();
    observe(32'(cpu_irq));
    // priority between simultaneous edges on 4 and 1
    wr(BASE, 32'h13F);
    wr(BASE + 4, 32'h3F);
    irq_src = 6'b010010;
    tick();
    irq_src = 0;
    expect_val("pr_cpu_hi", 1);
    tick();
    observe(32'(cpu_irq));
    expect_val("pr_id1", 1); expect_val("pr_pend_left", 32'h10);
    pulse_ack();
    observe(32'(irq_id));
    rd(BASE + 8, rdata); observe(rdata);
    wr(BASE + 12, 0);
    expect_val("pr_reassert", 1);
    tick();
    observe(32'(cpu_irq));
    expect_val("pr_id4", 4); expect_val("pr_isr4", 32'h8000_0004);
    pulse_ack();
    observe(32'(irq_id));
    rd(BASE + 12, rdata); observe(rdata);
    wr(BASE + 12, 0);
    // level source withdrawn before ack
    wr(BASE + 4, 0);
    wr(BASE, 32'h104);
    irq_src = 6'h04;
    expect_val("lv_cpu_hi", 1);
    tick();
    observe(32'(cpu_irq));
    irq_src = 0;
    expect_val("lv_cpu_drop", 0);
    tick();
    observe(32'(cpu_irq));
    expect_val("lv_late_ack", 0);
    pulse_ack();
    observe(32'(irq_active));
    // masking and global enable
    wr(BASE + 4, 32'h08);
    wr(BASE, 32'h100);
    irq_src = 6'h08;
    tick();
    irq_src = 0;
    repeat (2) tick();
    expect_val("mk_masked", 0); observe(32'(cpu_irq));
    expect_val("mk_pend", 32'h08); rd(BASE + 8, rdata); observe(rdata);
    wr(BASE, 32'h108);
    expect_val("mk_unmasked", 1);
    tick();
    observe(32'(cpu_irq));
    wr(BASE, 32'h008);
    expect_val("ge_drop", 0);
    tick();
    observe(32'(cpu_irq));
    expect_val("ge_pend_kept", 32'h08); rd(BASE + 8, rdata); observe(rdata);
    expect_val("ctrl_read", 32'h08); rd(BASE, rdata); observe(rdata);
    // edge beats W1C in the same cycle
    wr(BASE + 4, 32'h28);
    irq_src = 6'h20;
    wr(BASE + 8, 32'h20);
    irq_src = 0;
    expect_val("w1c_race", 32'h28); rd(BASE + 8, rdata); observe(rdata);
    wr(BASE + 8, 32'h20);
    expect_val("w1c_clear", 32'h08); rd(BASE + 8, rdata); observe(rdata);
    // async reset while in REQ
    wr(BASE, 32'h108);
    expect_val("rq_cpu_hi", 1);
    tick();
    observe(32'(cpu_irq));
    #2;
    reset = 0;
    #1;
    expect_val("ar_cpu_lo", 0); observe(32'(cpu_irq));
    expect_val("ar_active", 0); observe(32'(irq_active));
    for (int i = 0; i < 4; i++) begin
      expect_val($sformatf("ar_reg%0d", i), 0);
      rd(BASE + 32'(4 * i), rdata); observe(rdata);
    end
    reset = 1;
    tick();
    expect_val("ar_pend_lost", 0); rd(BASE + 8, rdata); observe(rdata);
    expect_val("ar_idle", 0); observe(32'(cpu_irq));
    chk("sb_drained", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
